// File: rtl/sumador_serie.sv
// rtl/sumador_serie.sv - bit-serial adder/subtractor processing BPC bits per clock
module sumador_serie #(
  parameter int W   = 8,
  parameter int BPC = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         busy,
  output logic         done
);

  localparam int S  = W / BPC;
  localparam int CW = $clog2(S) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_next;
  logic [W-1:0]   a_sr, b_sr, res_sr, res_shift;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic [BPC-1:0] slice_s;
  logic [BPC:0]   slice_c;
  logic           last;
  logic           accept;

  // Ripple full-adder slice over the BPC least significant operand bits.
  always_comb begin
    slice_s = '0;
    slice_c = '0;
    slice_c[0] = carry;
    for (int i = 0; i < BPC; i++) begin
      slice_s[i]   = a_sr[i] ^ b_sr[i] ^ slice_c[i];
      slice_c[i+1] = (a_sr[i] & b_sr[i]) | (slice_c[i] & (a_sr[i] ^ b_sr[i]));
    end
  end

  assign res_shift = W'({slice_s, res_sr} >> BPC);
  assign last      = (state == RUN) && (cnt == CW'(S - 1));
  assign accept    = (state == IDLE) && start;
  assign busy      = (state == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
        a_sr  <= a;
        b_sr  <= sub ? ~b : b;
        carry <= sub;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sr   <= a_sr >> BPC;
        b_sr   <= b_sr >> BPC;
        res_sr <= res_shift;
        carry  <= slice_c[BPC];
        cnt    <= cnt + CW'(1);
        if (last) begin
          sum  <= res_shift;
          cout <= slice_c[BPC];
          ovf  <= slice_c[BPC] ^ slice_c[BPC-1];
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/sumador_serie.md
Name: sumador_serie

Overview:
Parametrised bit-serial adder/subtractor, the sequential successor of the combinational half-adder cell. It accepts two W-bit operands on a start pulse and processes BPC bits per clock through an internal full-adder chain and a carry flip-flop. It then delivers sum, carry and signed overflow with a one-cycle done pulse. It serves as the datapath adder for the course's small sequential processors, where area matters more than latency.

Parameters:
W, 8, operand and result width in bits; must be at least 2.
BPC, 1, bits processed per clock; must divide W exactly. The number of processing steps is S = W/BPC.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled on clk rising edge, accepted only when busy=0
sub  input  1  mode, sampled with start: 0 = a+b, 1 = a-b (two's complement)
a  input  W  operand A, sampled with start
b  input  W  operand B, sampled with start
sum  output  W  result, registered
cout  output  1  carry out of MSB. In add mode it is the unsigned carry; in sub mode, 1 means no borrow (a >= b unsigned).
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when sum/cout/ovf become valid

Behaviour:
- Reset (asynchronous, any time, including mid-operation): state=IDLE; sum=0, cout=0, ovf=0, busy=0, done=0; the step counter and internal shift registers are cleared. An aborted operation produces no done pulse.
- FSM has two states, IDLE and RUN. A step counter (width clog2(S)+1) runs 0..S-1.
- IDLE, accept edge (E0): start=1 at the edge. Latch A into the shift register; latch B or ~B into the shift register according to sub. Load the carry flip-flop with sub. Counter=0, busy=1, next state RUN.
- IDLE with start=0: hold all outputs.
- RUN, each edge E1..ES:
  - The BPC LSBs of A and B plus the carry flip-flop feed a BPC-bit ripple full-adder slice.
  - The slice result shifts into the MSB end of the internal result register. A and B shift right by BPC.
  - The carry flip-flop takes the slice carry-out, and the counter increments.
- Final edge ES (counter = S-1):
  - sum takes the full internal result.
  - cout takes the slice carry-out.
  - ovf takes (carry into bit W-1) XOR (carry out of bit W-1), both taken from the final slice.
  - busy falls to 0, done rises to 1, next state IDLE.
- done drops at the following edge (ES+1). sum/cout/ovf hold their values until the next operation's final edge. They do not change at accept or during RUN.
- Latency: done is high exactly S cycles after the accept edge. The earliest next accept is edge ES+1, so throughput is one result per S+1 cycles.
- start during RUN (busy=1) is ignored; a, b and sub are not resampled. A start held high continuously is re-accepted at ES+1.
- Operand changes on a/b/sub after the accept edge have no effect on the result.
- Arithmetic is modulo 2^W. Sub is computed as a + ~b + 1.

Test Plan:
1. W=8, BPC=1, add 0x0F+0x01, start pulsed 1 cycle -> busy high for 8 cycles; done pulse 8 cycles after accept; sum=0x10, cout=0, ovf=0; done low the next cycle.
2. W=8, BPC=1, add 0xFF+0x01 -> sum=0x00, cout=1, ovf=0. Then add 0x7F+0x01 -> sum=0x80, cout=0, ovf=1.
3. W=8, BPC=1, sub 0x05-0x07 -> sum=0xFE, cout=0, ovf=0. Then sub 0x80-0x01 -> sum=0x7F, cout=1, ovf=1.
4. Start accepted with 0x03+0x04; change a/b/sub and pulse start at cycles 2 and 5 of RUN -> ignored; result sum=0x07. Next accept only at ES+1.
5. Reset asserted asynchronously at cycle 4 of an operation (between edges) -> busy, done, sum, cout, ovf go 0 immediately; no done pulse. A fresh 0x10+0x20 afterwards -> sum=0x30.
6. W=8, BPC=4 build, add 0xFF+0x01 -> done 2 cycles after accept, sum=0x00, cout=1. W=16, BPC=1, sub 0x0000-0x0001 -> done after 16 cycles, sum=0xFFFF, cout=0, ovf=0.
